// File: rtl/input_capture.sv
// input_capture: samples an asynchronous input, timestamps selected edges
// against a prescaled timebase and queues {timestamp, polarity} in a FIFO.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   capture_in          asynchronous signal under measurement
//   prescaler           timebase advances every prescaler+1 enabled cycles
//   capture_enable      runs the timebase and allows captures
//   edge_sel            00 none, 01 rising, 10 falling, 11 both
//   capture_clear       synchronous clear of timebase, prescaler, FIFO, overrun
//   rd_en               pop the FIFO head (ignored when empty)
//   capture_value       head timestamp, 0 when empty (decoded from head)
//   capture_edge        head polarity, 1 = rising, 0 when empty (decoded)
//   capture_valid       FIFO not empty (decoded)
//   capture_level       number of entries held
//   capture_overrun     sticky, an edge was dropped on a full FIFO
//   capture_interrupt   one-cycle pulse per accepted push
//   timebase            current timebase value
module input_capture #(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture_in,
  input  logic [7:0]                    prescaler,
  input  logic                          capture_enable,
  input  logic [1:0]                    edge_sel,
  input  logic                          capture_clear,
  input  logic                          rd_en,
  output logic [COUNT_W-1:0]            capture_value,
  output logic                          capture_edge,
  output logic                          capture_valid,
  output logic [$clog2(FIFO_DEPTH):0]   capture_level,
  output logic                          capture_overrun,
  output logic                          capture_interrupt,
  output logic [COUNT_W-1:0]            timebase
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [COUNT_W-1:0] value;
    logic               pol;
  } cap_entry_t;

  logic             s1, s2, prev;
  logic [7:0]       psc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  cap_entry_t       mem [FIFO_DEPTH];

  logic rise, fall, qual;
  logic fifo_full, fifo_empty;
  logic do_push, do_pop, drop;
  logic tb_step;

  // Two-flop synchronizer plus history flop; runs regardless of enable/clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= capture_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Edge qualification and FIFO handshake decode
  always_comb begin
    rise       = s2 & ~prev;
    fall       = ~s2 & prev;
    qual       = capture_enable & ((rise & edge_sel[0]) | (fall & edge_sel[1]));
    fifo_full  = (capture_level == FULL_LVL);
    fifo_empty = (capture_level == '0);
    do_pop     = rd_en & ~fifo_empty;
    // A pop on a full FIFO frees the slot this same push needs
    do_push    = qual & (~fifo_full | do_pop);
    drop       = qual & fifo_full & ~do_pop;
    tb_step    = capture_enable & (psc == prescaler);
  end

  // Prescale counter and timebase; psc wraps through 255 if prescaler drops below it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc      <= 8'd0;
      timebase <= '0;
    end else if (capture_clear) begin
      psc      <= 8'd0;
      timebase <= '0;
    end else if (capture_enable) begin
      if (tb_step) begin
        psc      <= 8'd0;
        timebase <= timebase + COUNT_W'(1);
      end else begin
        psc <= psc + 8'd1;
      end
    end
  end

  // FIFO storage; timebase here is the value before this edge's increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (!capture_clear && do_push) begin
      mem[wr_ptr] <= '{value: timebase, pol: rise};
    end
  end

  // FIFO pointers, level, overrun and interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      capture_level     <= '0;
      capture_overrun   <= 1'b0;
      capture_interrupt <= 1'b0;
    end else if (capture_clear) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      capture_level     <= '0;
      capture_overrun   <= 1'b0;
      capture_interrupt <= 1'b0;
    end else begin
      capture_interrupt <= do_push;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        capture_level <= capture_level + LVL_W'(1);
      end else if (!do_push && do_pop) begin
        capture_level <= capture_level - LVL_W'(1);
      end
      if (drop) begin
        capture_overrun <= 1'b1;
      end
    end
  end

  // Head decode; zeroed when empty
  always_comb begin
    capture_valid = ~fifo_empty;
    capture_value = '0;
    capture_edge  = 1'b0;
    if (capture_valid) begin
      capture_value = mem[rd_ptr].value;
      capture_edge  = mem[rd_ptr].pol;
    end
  end

endmodule

// File: tb/tb_input_capture.sv
module tb_input_capture;

  logic        clk;
  logic        rst;
  logic        capture_in;
  logic [7:0]  prescaler;
  logic        capture_enable;
  logic [1:0]  edge_sel;
  logic        capture_clear;
  logic        rd_en;
  logic [31:0] capture_value;
  logic        capture_edge;
  logic        capture_valid;
  logic [2:0]  capture_level;
  logic        capture_overrun;
  logic        capture_interrupt;
  logic [31:0] timebase;

  // Narrow-timebase instance for the wrap check
  logic        en_w;
  logic        zero_w;
  logic [7:0]  psc_w;
  logic [1:0]  sel_w;
  logic [7:0]  value_w;
  logic        edge_w;
  logic        valid_w;
  logic [2:0]  level_w;
  logic        ovr_w;
  logic        irq_w;
  logic [7:0]  tb_w;

  int n_cmp;
  int n_err;
  int irq_cnt;
  logic [31:0] v_a;

  input_capture #(.COUNT_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .capture_in(capture_in), .prescaler(prescaler),
    .capture_enable(capture_enable), .edge_sel(edge_sel),
    .capture_clear(capture_clear), .rd_en(rd_en),
    .capture_value(capture_value), .capture_edge(capture_edge),
    .capture_valid(capture_valid), .capture_level(capture_level),
    .capture_overrun(capture_overrun), .capture_interrupt(capture_interrupt),
    .timebase(timebase)
  );

  input_capture #(.COUNT_W(8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .capture_in(zero_w), .prescaler(psc_w),
    .capture_enable(en_w), .edge_sel(sel_w),
    .capture_clear(zero_w), .rd_en(zero_w),
    .capture_value(value_w), .capture_edge(edge_w),
    .capture_valid(valid_w), .capture_level(level_w),
    .capture_overrun(ovr_w), .capture_interrupt(irq_w),
    .timebase(tb_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (capture_interrupt === 1'b1) irq_cnt++;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    capture_clear = 1'b1;
    tick();
    capture_clear = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; irq_cnt = 0;
    rst = 1'b0; capture_in = 1'b0; prescaler = 8'd0; capture_enable = 1'b0;
    edge_sel = 2'b00; capture_clear = 1'b0; rd_en = 1'b0;
    en_w = 1'b0; zero_w = 1'b0; psc_w = 8'd0; sel_w = 2'b00;

    // Reset state
    repeat (3) tick();
    check("rst_value", capture_value, 0);
    check("rst_edge", capture_edge, 0);
    check("rst_valid", capture_valid, 0);
    check("rst_level", capture_level, 0);
    check("rst_overrun", capture_overrun, 0);
    check("rst_irq", capture_interrupt, 0);
    check("rst_timebase", timebase, 0);
    rst = 1'b1;
    tick();

    // Prescaler 9, rising only, 200-clk square wave
    prescaler = 8'd9; edge_sel = 2'b01; capture_enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      irq_cnt = 0;
      capture_in = 1'b1;
      repeat (100) tick();
      capture_in = 1'b0;
      repeat (100) tick();
      check("sq_irq_per_period", irq_cnt, 1);
    end
    check("sq_timebase", timebase, 60);
    check("sq_level", capture_level, 3);
    check("sq_head0", capture_value, 0);
    check("sq_edge0", capture_edge, 1);
    pop();
    check("sq_head1", capture_value, 20);
    pop();
    check("sq_head2", capture_value, 40);
    pop();
    check("sq_empty_valid", capture_valid, 0);
    check("sq_empty_value", capture_value, 0);
    pop();
    check("sq_pop_empty_level", capture_level, 0);

    // Both edges, prescaler 0, 60 high / 140 low
    prescaler = 8'd0; edge_sel = 2'b11;
    do_clear();
    capture_in = 1'b1;
    repeat (60) tick();
    capture_in = 1'b0;
    repeat (140) tick();
    check("both_level", capture_level, 2);
    check("both_rise_val", capture_value, 2);
    check("both_rise_edge", capture_edge, 1);
    v_a = capture_value;
    pop();
    check("both_fall_val", capture_value, 62);
    check("both_fall_edge", capture_edge, 0);
    check("both_diff", capture_value - v_a, 60);
    pop();
    check("both_empty", capture_valid, 0);

    // Five rising edges into a 4-deep FIFO with no reads
    edge_sel = 2'b01;
    do_clear();
    irq_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      capture_in = 1'b1;
      repeat (4) tick();
      capture_in = 1'b0;
      repeat (4) tick();
    end
    check("ovr_irq_cnt", irq_cnt, 4);
    check("ovr_level", capture_level, 4);
    check("ovr_flag", capture_overrun, 1);
    check("ovr_head", capture_value, 2);
    pop();
    check("ovr_pop1", capture_value, 10);
    pop();
    check("ovr_pop2", capture_value, 18);
    pop();
    check("ovr_pop3", capture_value, 26);
    pop();
    check("ovr_drained", capture_valid, 0);
    check("ovr_sticky", capture_overrun, 1);

    // Full FIFO, pop on the same cycle as a push
    do_clear();
    check("clr_overrun", capture_overrun, 0);
    for (int k = 0; k < 4; k++) begin
      capture_in = 1'b1;
      repeat (4) tick();
      capture_in = 1'b0;
      repeat (4) tick();
    end
    check("pp_full_level", capture_level, 4);
    capture_in = 1'b1;
    tick();
    tick();
    pop();
    check("pp_level", capture_level, 4);
    check("pp_overrun", capture_overrun, 0);
    check("pp_irq", capture_interrupt, 1);
    check("pp_head", capture_value, 10);
    pop();
    pop();
    pop();
    check("pp_tail", capture_value, 34);
    check("pp_tail_level", capture_level, 1);

    // Clear in the same cycle as a qualified edge
    capture_in = 1'b0;
    repeat (4) tick();
    capture_in = 1'b1;
    tick();
    tick();
    do_clear();
    check("ce_level", capture_level, 0);
    check("ce_timebase", timebase, 0);
    check("ce_irq", capture_interrupt, 0);
    check("ce_valid", capture_valid, 0);
    tick();
    check("ce_irq_after", capture_interrupt, 0);
    check("ce_level_after", capture_level, 0);
    check("ce_tb_after", timebase, 1);

    // Disabled: timebase holds and edges are ignored
    capture_enable = 1'b0;
    capture_in = 1'b0;
    repeat (4) tick();
    capture_in = 1'b1;
    repeat (4) tick();
    check("dis_timebase", timebase, 1);
    check("dis_level", capture_level, 0);

    // One entry resident, then wrap the 8-bit instance
    capture_enable = 1'b1;
    capture_in = 1'b0;
    repeat (3) tick();
    capture_in = 1'b1;
    repeat (3) tick();
    check("pre_rst_valid", capture_valid, 1);
    check("pre_rst_value", capture_value, 6);
    capture_in = 1'b0;
    en_w = 1'b1;
    repeat (255) tick();
    check("wrap_255", tb_w, 255);
    tick();
    check("wrap_0", tb_w, 0);
    repeat (44) tick();
    check("wrap_44", tb_w, 44);

    // Asynchronous reset mid-run, checked before the next clock edge
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", capture_valid, 0);
    check("arst_value", capture_value, 0);
    check("arst_edge", capture_edge, 0);
    check("arst_level", capture_level, 0);
    check("arst_overrun", capture_overrun, 0);
    check("arst_irq", capture_interrupt, 0);
    check("arst_timebase", timebase, 0);
    check("arst_tb_w", tb_w, 0);
    #1;
    rst = 1'b1;
    tick();
    check("resume_timebase", timebase, 1);
    check("resume_tb_w", tb_w, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
